// File: rtl/vr_loc_pkg.sv
// Shared definitions for the VR location quantiser.
// Contents: the width of the LOC bus, the reset LOC value, the FSM state type,
// and elaboration-time helpers for the detent step width and its log2.
// Nothing here is tied to a particular configuration.
package vr_loc_pkg;

  localparam int              LOC_W   = 8;
  localparam logic [LOC_W-1:0] LOC_RST = 8'h80;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  // Smallest r such that 2**r >= v. Used only with power-of-two inputs.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of LOC codes covered by one detent step.
  function automatic int step_width(input int steps);
    return (1 << LOC_W) / steps;
  endfunction

endpackage

// File: rtl/vr_loc_evt_buf.sv
// One-deep valid/ready event register for committed step changes.
// The payload (step, direction) is held here and doubles as the committed
// position seen by the rest of the design.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   commit_i        load a new event this cycle
//   step_i, dir_i   payload of the new event
//   rdy_i           consumer accepts when vld_o & rdy_i at a rising edge
//   ovr_clr_i       synchronous clear of the overwrite flag
//   vld_o           event pending
//   step_o, dir_o   current payload / committed position
//   ovr_o           sticky: a pending event was replaced before it was taken
module vr_loc_evt_buf
  import vr_loc_pkg::*;
#(
  parameter int                STEP_W   = 4,
  parameter logic [STEP_W-1:0] STEP_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              commit_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              dir_i,
  input  logic              rdy_i,
  input  logic              ovr_clr_i,
  output logic              vld_o,
  output logic [STEP_W-1:0] step_o,
  output logic              dir_o,
  output logic              ovr_o
);

  logic              vld_q, vld_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dir_q, dir_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    vld_d  = vld_q;
    step_d = step_q;
    dir_d  = dir_q;
    ovr_d  = ovr_q;

    // A commit always leaves an event pending, even when the old one is
    // being accepted on the same edge.
    if (commit_i) begin
      vld_d  = 1'b1;
      step_d = step_i;
      dir_d  = dir_i;
    end else if (vld_q && rdy_i) begin
      vld_d = 1'b0;
    end

    // Setting beats a same-cycle clear.
    if (commit_i && vld_q && !rdy_i) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      step_q <= STEP_RST;
      dir_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      ovr_q  <= ovr_d;
    end
  end

  assign vld_o  = vld_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/vr_loc_quant.sv
// Quantises the VR detector's 8-bit location into C_STEPS detent steps with
// hysteresis and a settle timer, and reports each committed step change as
// an event over a valid/ready handshake.
// Optional build macro: VR_LOC_QUANT_SLEW_EN -- when defined, every commit
// moves one step toward the target (a k-step jump gives k events); when
// undefined, a commit jumps straight to the target.
// Ports:
//   CK_i        clock
//   XARST_i     asynchronous active-low reset
//   EN_CK_i     qualifies settle counting only (tie high when unused)
//   LOC_i       location from detector
//   STEP_o      committed step index
//   DIR_o       direction of last commit, 1 = up
//   EVT_VLD_o   event valid
//   EVT_RDY_i   event accepted when VLD & RDY at a rising edge
//   OVR_o       sticky overwrite flag
//   OVR_CLR_i   synchronous clear of OVR_o
module vr_loc_quant
  import vr_loc_pkg::*;
#(
  parameter int  C_STEPS  = 16,
  parameter int  C_HYS    = 4,
  parameter int  C_SETTLE = 1024,
  localparam int STEP_W   = log2c(C_STEPS)
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  input  logic              EN_CK_i,
  input  logic [LOC_W-1:0]  LOC_i,
  output logic [STEP_W-1:0] STEP_o,
  output logic              DIR_o,
  output logic              EVT_VLD_o,
  input  logic              EVT_RDY_i,
  output logic              OVR_o,
  input  logic              OVR_CLR_i
);

  localparam int                W        = step_width(C_STEPS);
  localparam int                SH       = log2c(W);
  localparam logic [STEP_W-1:0] STEP_RST = STEP_W'(C_STEPS / 2);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(C_STEPS - 1);

  logic [LOC_W-1:0]  loc_d_q;
  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [16:0]       cnt_inc;
  logic [STEP_W-1:0] cand_q, cand_d;
  logic [STEP_W-1:0] cand;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] tgt;
  logic              tgt_up;
  logic              commit;
  logic              outside;

  // Window arithmetic is done in 11-bit signed so lo may go negative and
  // hi may exceed 255 without wrapping.
  logic signed [10:0] base_s, lo_s, hi_s, loc_s;

  assign base_s = $signed(11'(step) << SH);
  assign lo_s   = base_s - $signed(11'(C_HYS));
  assign hi_s   = base_s + $signed(11'(W - 1 + C_HYS));
  assign loc_s  = $signed({3'b000, loc_d_q});

  // The bottom step has no lower edge and the top step no upper edge.
  assign outside = ((step != '0)      && (loc_s < lo_s)) ||
                   ((step != STEP_MAX) && (loc_s > hi_s));

  assign cand    = STEP_W'(loc_d_q >> SH);
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

`ifdef VR_LOC_QUANT_SLEW_EN
  assign tgt = (cand_q > step) ? step + STEP_W'(1) : step - STEP_W'(1);
`else
  assign tgt = cand_q;
`endif
  assign tgt_up = (tgt > step);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (outside && EN_CK_i) begin
          state_d = SETTLE;
          cand_d  = cand;
          cnt_d   = 16'd1;
        end
      end
      SETTLE: begin
        if (!outside) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cand != cand_q) begin
          cand_d = cand;
          cnt_d  = 16'd1;
        end else if (EN_CK_i) begin
          // Commit on the edge where the count would reach C_SETTLE.
          if (cnt_inc >= 17'(C_SETTLE)) begin
            commit  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[15:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      loc_d_q <= LOC_RST;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= STEP_RST;
    end else begin
      loc_d_q <= LOC_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  vr_loc_evt_buf #(
    .STEP_W   (STEP_W),
    .STEP_RST (STEP_RST)
  ) u_evt_buf (
    .clk_i     (CK_i),
    .rst_ni    (XARST_i),
    .commit_i  (commit),
    .step_i    (tgt),
    .dir_i     (tgt_up),
    .rdy_i     (EVT_RDY_i),
    .ovr_clr_i (OVR_CLR_i),
    .vld_o     (EVT_VLD_o),
    .step_o    (step),
    .dir_o     (DIR_o),
    .ovr_o     (OVR_o)
  );

  assign STEP_o = step;

endmodule

// File: tb/tb_vr_loc_quant.sv
module tb_vr_loc_quant;

  localparam int C_STEPS  = 16;
  localparam int C_HYS    = 4;
  localparam int C_SETTLE = 8;

  logic       CK        = 1'b0;
  logic       XARST_i   = 1'b0;
  logic       EN_CK_i   = 1'b1;
  logic [7:0] LOC_i     = 8'h80;
  logic       EVT_RDY_i = 1'b0;
  logic       OVR_CLR_i = 1'b0;
  logic [3:0] STEP_o;
  logic       DIR_o;
  logic       EVT_VLD_o;
  logic       OVR_o;

  typedef struct packed {
    logic [3:0] step;
    logic       dir;
  } evt_t;

  evt_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   idx;
  int   gap;

  always #5 CK = ~CK;

  vr_loc_quant #(
    .C_STEPS  (C_STEPS),
    .C_HYS    (C_HYS),
    .C_SETTLE (C_SETTLE)
  ) dut (
    .CK_i      (CK),
    .XARST_i   (XARST_i),
    .EN_CK_i   (EN_CK_i),
    .LOC_i     (LOC_i),
    .STEP_o    (STEP_o),
    .DIR_o     (DIR_o),
    .EVT_VLD_o (EVT_VLD_o),
    .EVT_RDY_i (EVT_RDY_i),
    .OVR_o     (OVR_o),
    .OVR_CLR_i (OVR_CLR_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Ticks until STEP_o changes (bounded); gap is 0 if it never changed.
  task automatic wait_change(output int g);
    logic [3:0] s0;
    s0 = STEP_o;
    g  = 0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (STEP_o != s0) begin
        g = k;
        break;
      end
    end
  endtask

  // Scoreboard: an accepted event must match the oldest expected one.
  always @(negedge CK) begin
    evt_t e;
    if (XARST_i && EVT_VLD_o && EVT_RDY_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_evt", 32'({STEP_o, DIR_o}), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("evt_step", 32'(STEP_o), 32'(e.step));
        chk("evt_dir",  32'(DIR_o),  32'(e.dir));
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_step", 32'(STEP_o), 32'd8);
    chk("rst_dir",  32'(DIR_o), 32'd0);
    chk("rst_vld",  32'(EVT_VLD_o), 32'd0);
    chk("rst_ovr",  32'(OVR_o), 32'd0);

    XARST_i = 1'b1;
    tick(20);
    chk("idle_step", 32'(STEP_o), 32'd8);
    chk("idle_vld",  32'(EVT_VLD_o), 32'd0);
    chk("idle_ovr",  32'(OVR_o), 32'd0);

    // Exactly on the upper hysteresis edge: no change.
    LOC_i = 8'h93;
    tick(50);
    chk("hi_edge_step", 32'(STEP_o), 32'd8);
    chk("hi_edge_vld",  32'(EVT_VLD_o), 32'd0);

    // Short excursion then back inside.
    LOC_i = 8'h94;
    tick(5);
    LOC_i = 8'h80;
    tick(20);
    chk("glitch_step", 32'(STEP_o), 32'd8);
    chk("glitch_vld",  32'(EVT_VLD_o), 32'd0);

    // Candidate keeps changing: settle restarts every time.
    for (int i = 0; i < 6; i++) begin
      LOC_i = i[0] ? 8'hA4 : 8'h94;
      tick(4);
    end
    LOC_i = 8'h80;
    tick(10);
    chk("toggle_step", 32'(STEP_o), 32'd8);
    chk("toggle_vld",  32'(EVT_VLD_o), 32'd0);

    // Exact latency: commit on edge C_SETTLE+1.
    LOC_i = 8'h94;
    tick(8);
    chk("lat_pre_step", 32'(STEP_o), 32'd8);
    chk("lat_pre_vld",  32'(EVT_VLD_o), 32'd0);
    sb_q.push_back(evt_t'{4'd9, 1'b1});
    tick(1);
    chk("lat_step", 32'(STEP_o), 32'd9);
    chk("lat_dir",  32'(DIR_o), 32'd1);
    chk("lat_vld",  32'(EVT_VLD_o), 32'd1);
    EVT_RDY_i = 1'b1;
    tick(1);
    chk("acc_vld", 32'(EVT_VLD_o), 32'd0);

    // Step down 9 -> 8.
    LOC_i = 8'h80;
    sb_q.push_back(evt_t'{4'd8, 1'b0});
    tick(9);
    chk("down_step", 32'(STEP_o), 32'd8);
    chk("down_dir",  32'(DIR_o), 32'd0);
    tick(2);

    // Settle counts only qualified cycles.
    LOC_i = 8'h94;
    sb_q.push_back(evt_t'{4'd9, 1'b1});
    idx = 0;
    for (int k = 1; k <= 40 && idx == 0; k++) begin
      EN_CK_i = k[0];
      tick(1);
      if (STEP_o == 4'd9) idx = k;
    end
    chk("en_lat_16_17", 32'(idx >= 16 && idx <= 17), 32'd1);
    EN_CK_i = 1'b1;
    tick(2);
    chk("en_step", 32'(STEP_o), 32'd9);

    LOC_i = 8'h80;
    sb_q.push_back(evt_t'{4'd8, 1'b0});
    tick(11);
    chk("back_step", 32'(STEP_o), 32'd8);
    EVT_RDY_i = 1'b0;

`ifdef VR_LOC_QUANT_SLEW_EN
    LOC_i = 8'h00;
    tick(9);
    chk("slew1_step", 32'(STEP_o), 32'd7);
    chk("slew1_dir",  32'(DIR_o), 32'd0);
    chk("slew1_vld",  32'(EVT_VLD_o), 32'd1);
    chk("slew1_ovr",  32'(OVR_o), 32'd0);
    wait_change(gap);
    chk("slew2_gap",  32'(gap >= 8 && gap <= 9), 32'd1);
    chk("slew2_step", 32'(STEP_o), 32'd6);
    chk("slew2_ovr",  32'(OVR_o), 32'd1);
    OVR_CLR_i = 1'b1;
    tick(1);
    OVR_CLR_i = 1'b0;
    chk("slew_clr_ovr", 32'(OVR_o), 32'd0);
    wait_change(gap);
    chk("slew3_step", 32'(STEP_o), 32'd5);
    chk("slew3_ovr",  32'(OVR_o), 32'd1);
`else
    // Large jump: one event straight to the target.
    LOC_i = 8'h00;
    tick(9);
    chk("big_step", 32'(STEP_o), 32'd0);
    chk("big_dir",  32'(DIR_o), 32'd0);
    chk("big_vld",  32'(EVT_VLD_o), 32'd1);
    chk("big_ovr",  32'(OVR_o), 32'd0);
    tick(30);
    chk("big_hold_step", 32'(STEP_o), 32'd0);
    chk("big_hold_vld",  32'(EVT_VLD_o), 32'd1);
    sb_q.push_back(evt_t'{4'd0, 1'b0});
    EVT_RDY_i = 1'b1;
    tick(1);
    EVT_RDY_i = 1'b0;
    chk("big_acc_vld", 32'(EVT_VLD_o), 32'd0);

    // Overwrite of an unconsumed event.
    LOC_i = 8'h80;
    tick(9);
    chk("ow1_step", 32'(STEP_o), 32'd8);
    chk("ow1_dir",  32'(DIR_o), 32'd1);
    chk("ow1_ovr",  32'(OVR_o), 32'd0);
    LOC_i = 8'hFF;
    tick(9);
    chk("ow2_step", 32'(STEP_o), 32'd15);
    chk("ow2_vld",  32'(EVT_VLD_o), 32'd1);
    chk("ow2_ovr",  32'(OVR_o), 32'd1);
    OVR_CLR_i = 1'b1;
    tick(1);
    OVR_CLR_i = 1'b0;
    chk("clr_ovr", 32'(OVR_o), 32'd0);
    chk("clr_vld", 32'(EVT_VLD_o), 32'd1);

    // Accept and commit on the same edge: no overwrite, valid stays high.
    sb_q.push_back(evt_t'{4'd15, 1'b1});
    sb_q.push_back(evt_t'{4'd8, 1'b0});
    LOC_i = 8'h80;
    tick(8);
    EVT_RDY_i = 1'b1;
    tick(1);
    chk("simul_step", 32'(STEP_o), 32'd8);
    chk("simul_dir",  32'(DIR_o), 32'd0);
    chk("simul_vld",  32'(EVT_VLD_o), 32'd1);
    chk("simul_ovr",  32'(OVR_o), 32'd0);
    tick(1);
    EVT_RDY_i = 1'b0;
    chk("simul_drain_vld", 32'(EVT_VLD_o), 32'd0);

    LOC_i = 8'h00;
    tick(4);
`endif

    // Asynchronous reset mid-settle.
    #2;
    XARST_i = 1'b0;
    #1;
    chk("arst_step", 32'(STEP_o), 32'd8);
    chk("arst_dir",  32'(DIR_o), 32'd0);
    chk("arst_vld",  32'(EVT_VLD_o), 32'd0);
    chk("arst_ovr",  32'(OVR_o), 32'd0);
    LOC_i = 8'h80;
    tick(2);
    XARST_i = 1'b1;
    tick(12);
    chk("post_rst_step", 32'(STEP_o), 32'd8);
    chk("post_rst_vld",  32'(EVT_VLD_o), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
